// File: rtl/exu_seq.sv
// rtl/exu_seq.sv - EXU sequencer: accepts decoded ops, times single/multi-cycle
// execution, and presents results to the WBU with branch redirect.
module exu_seq #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_multi,
  input  logic        in_is_branch,
  input  logic [4:0]  in_rd,
  output logic        ex_en,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_branch_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        multi_q;
  logic        branch_q;
  logic [31:0] out_data_q;
  logic [4:0]  out_rd_q;
  logic [31:0] redirect_pc_q;

  logic out_hs;
  logic taken;
  logic accept;

  assign out_hs = (state_q == RESP) && out_ready;
  assign taken  = out_hs && branch_q && out_data_q[0];

  // A retiring taken branch refuses the next op so the IDU can refetch first.
  assign in_ready = rst_n && !flush &&
                    ((state_q == IDLE) || (out_hs && !taken));
  assign accept   = in_valid && in_ready;

  assign ex_en       = accept;
  assign out_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign redirect    = taken && !flush;
  assign redirect_pc = redirect_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      multi_q       <= 1'b0;
      branch_q      <= 1'b0;
      out_data_q    <= '0;
      out_rd_q      <= '0;
      redirect_pc_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        EXEC: begin
          if (multi_q) begin
            cnt_q   <= 4'(MUL_LAT - 2);
            state_q <= WAIT;
          end else begin
            out_data_q    <= ex_result;
            redirect_pc_q <= ex_branch_pc;
            state_q       <= RESP;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            out_data_q    <= ex_result;
            redirect_pc_q <= ex_branch_pc;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Placed after the case so a back-to-back accept in RESP wins over IDLE.
      if (accept) begin
        multi_q  <= in_multi;
        branch_q <= in_is_branch;
        out_rd_q <= in_is_branch ? 5'd0 : in_rd;
        state_q  <= EXEC;
      end
    end
  end

endmodule

// File: tb/tb_exu_seq.sv
// tb/tb_exu_seq.sv - self-checking bench for exu_seq: directed table,
// hand-written corner sequences and a randomized transaction-level model.
module tb_exu_seq;
  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_multi = 1'b0;
  logic        in_is_branch = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        ex_en;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_branch_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  exu_seq #(.MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_multi(in_multi),
    .in_is_branch(in_is_branch), .in_rd(in_rd), .ex_en(ex_en),
    .ex_result(ex_result), .ex_branch_pc(ex_branch_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        multi;
    logic        branch;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] pc;
    int          delay;
    int          exp_lat;
    logic [4:0]  exp_rd;
    logic        exp_redir;
  } tv_t;

  tv_t tv[6];

  task automatic wait_resp(input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      #1;
      if (!out_valid) chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    end while (!out_valid && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic offer(input logic m, input logic b, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] pc);
    in_valid = 1'b1; in_multi = m; in_is_branch = b; in_rd = rd;
    ex_result = res; ex_branch_pc = pc;
  endtask

  task automatic run_op(input tv_t t);
    @(negedge clk);
    offer(t.multi, t.branch, t.rd, t.res, t.pc);
    out_ready = 1'b0;
    #1;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    chk("accept_ex_en", 32'(ex_en), 32'd1);
    wait_resp(t.exp_lat, "op");
    chk("resp_busy", 32'(busy), 32'd1);
    chk("out_data", out_data, t.res);
    chk("out_rd", 32'(out_rd), 32'(t.exp_rd));
    repeat (t.delay) begin
      @(negedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, t.res);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_redirect", 32'(redirect), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("hs_redirect", 32'(redirect), 32'(t.exp_redir));
    if (t.exp_redir) chk("hs_redirect_pc", redirect_pc, t.pc);
    chk("hs_in_ready", 32'(in_ready), 32'(!t.exp_redir));
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_redirect", 32'(redirect), 32'd0);
  endtask

  // Transaction-level reference: one op in flight, ready at accept cycle + latency.
  logic        m_have, m_branch, m_multi;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_pc, cur_res, cur_pc;
  int          m_rdy, cyc;
  logic        resp, tk, e_ready, e_en;

  initial begin
    tv[0] = '{1'b0, 1'b0, 5'd5,  32'h12345678, 32'h0,        0, 2,      5'd5,  1'b0};
    tv[1] = '{1'b1, 1'b0, 5'd9,  32'hDEADBEEF, 32'h0,        0, ML + 1, 5'd9,  1'b0};
    tv[2] = '{1'b0, 1'b1, 5'd7,  32'hFFFFFFFF, 32'h80000010, 0, 2,      5'd0,  1'b1};
    tv[3] = '{1'b0, 1'b1, 5'd3,  32'h00000000, 32'h00001234, 1, 2,      5'd0,  1'b0};
    tv[4] = '{1'b0, 1'b0, 5'd31, 32'hA5A5A5A5, 32'h0,        3, 2,      5'd31, 1'b0};
    tv[5] = '{1'b1, 1'b1, 5'd12, 32'hFFFFFFFF, 32'h40000200, 2, ML + 1, 5'd0,  1'b1};

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_ex_en", 32'(ex_en), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_op(tv[i]);

    // Taken branch retiring with a same-cycle offer: offer must be refused.
    @(negedge clk);
    offer(1'b0, 1'b1, 5'd4, 32'hFFFFFFFF, 32'h80000010);
    wait_resp(2, "br");
    out_ready = 1'b1; in_valid = 1'b1; in_is_branch = 1'b0;
    #1;
    chk("br_redirect", 32'(redirect), 32'd1);
    chk("br_redirect_pc", redirect_pc, 32'h80000010);
    chk("br_out_rd", 32'(out_rd), 32'd0);
    chk("br_in_ready", 32'(in_ready), 32'd0);
    chk("br_ex_en", 32'(ex_en), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("br_redirect_once", 32'(redirect), 32'd0);
    chk("br_idle", 32'(busy), 32'd0);

    // Back-to-back: new op accepted in the handshake cycle, no bubble.
    @(negedge clk);
    offer(1'b0, 1'b0, 5'd1, 32'h11111111, 32'h0);
    wait_resp(2, "b2b_a");
    out_ready = 1'b1;
    offer(1'b0, 1'b0, 5'd2, 32'h22222222, 32'h0);
    #1;
    chk("b2b_ex_en", 32'(ex_en), 32'd1);
    chk("b2b_old_data", out_data, 32'h11111111);
    wait_resp(2, "b2b_b");
    chk("b2b_new_data", out_data, 32'h22222222);
    chk("b2b_new_rd", 32'(out_rd), 32'd2);
    @(negedge clk);
    out_ready = 1'b0;

    // Flush in WAIT.
    @(negedge clk);
    offer(1'b1, 1'b0, 5'd6, 32'h0BADF00D, 32'h0);
    repeat (2) @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fw_in_ready", 32'(in_ready), 32'd0);
    chk("fw_ex_en", 32'(ex_en), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fw_out_valid", 32'(out_valid), 32'd0);
    chk("fw_busy", 32'(busy), 32'd0);
    chk("fw_in_ready_after", 32'(in_ready), 32'd1);
    repeat (ML + 2) begin @(negedge clk); #1 chk("fw_no_late_valid", 32'(out_valid), 32'd0); end

    // Flush in RESP with a taken branch handshaking: no redirect, result dropped.
    @(negedge clk);
    offer(1'b0, 1'b1, 5'd8, 32'hFFFFFFFF, 32'h00008000);
    wait_resp(2, "fr");
    flush = 1'b1; out_ready = 1'b1;
    #1 chk("fr_redirect", 32'(redirect), 32'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("fr_out_valid", 32'(out_valid), 32'd0);
    chk("fr_in_ready_after", 32'(in_ready), 32'd1);

    // Async reset mid-WAIT, then a full op with correct latency.
    @(negedge clk);
    offer(1'b1, 1'b0, 5'd10, 32'h5555AAAA, 32'h0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_ex_en", 32'(ex_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_in_ready", 32'(in_ready), 32'd1);
    run_op(tv[1]);

    // Randomized run against the transaction model.
    m_have = 1'b0; m_branch = 1'b0; m_multi = 1'b0; m_rd = '0;
    m_res = '0; m_pc = '0; m_rdy = 0; cyc = 0; cur_res = '0; cur_pc = '0;
    repeat (3000) begin
      @(negedge clk);
      resp = m_have && (cyc >= m_rdy);
      flush        = ($urandom % 25) == 0;
      out_ready    = ($urandom % 3) != 0;
      in_valid     = ($urandom % 3) != 0;
      in_multi     = 1'($urandom % 2);
      in_is_branch = ($urandom % 3) == 0;
      in_rd        = 5'($urandom);
      if (!m_have || resp) begin
        cur_res = in_is_branch ? {32{1'($urandom % 2)}} : 32'($urandom);
        cur_pc  = 32'($urandom);
        ex_result = cur_res; ex_branch_pc = cur_pc;
      end
      tk      = resp && out_ready && m_branch && m_res[0];
      e_ready = !flush && (!m_have || (resp && out_ready && !tk));
      e_en    = in_valid && e_ready;
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(e_ready));
      chk("rnd_ex_en", 32'(ex_en), 32'(e_en));
      chk("rnd_out_valid", 32'(out_valid), 32'(resp));
      chk("rnd_busy", 32'(busy), 32'(m_have));
      chk("rnd_redirect", 32'(redirect), 32'(tk && !flush));
      if (resp) begin
        chk("rnd_out_data", out_data, m_res);
        chk("rnd_out_rd", 32'(out_rd), 32'(m_branch ? 5'd0 : m_rd));
      end
      if (tk && !flush) chk("rnd_redirect_pc", redirect_pc, m_pc);
      if (flush) m_have = 1'b0;
      else begin
        if (resp && out_ready) m_have = 1'b0;
        if (e_en) begin
          m_have = 1'b1; m_branch = in_is_branch; m_multi = in_multi; m_rd = in_rd;
          m_res = cur_res; m_pc = cur_pc;
          m_rdy = cyc + (in_multi ? ML + 1 : 2);
        end
      end
      cyc++;
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_seq.md
EXU_SEQ -- requirements
Module: exu_seq

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles a multi-cycle ALU operation occupies; legal range 2..15.
REQ-002 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 Port in_valid  input  1  IDU offers a decoded instruction.
REQ-006 Port in_ready  output  1  sequencer accepts the offered instruction.
REQ-007 Port in_multi  input  1  offered op is multi-cycle; waits MUL_LAT cycles.
REQ-008 Port in_is_branch  input  1  offered op is a conditional branch.
REQ-009 Port in_rd  input  5  destination register index.
REQ-010 Port ex_en  output  1  one-cycle strobe that latches operands into the EXU datapath.
REQ-011 Port ex_result  input  32  EXU result (branch result is all-ones or all-zeros).
REQ-012 Port ex_branch_pc  input  32  EXU branch target.
REQ-013 Port out_valid  output  1  result offered to WBU.
REQ-014 Port out_ready  input  1  WBU accepts result.
REQ-015 Port out_data  output  32  registered result.
REQ-016 Port out_rd  output  5  registered destination index; forced 0 for branches.
REQ-017 Port redirect  output  1  one-cycle pulse: taken branch retired.
REQ-018 Port redirect_pc  output  32  target accompanying redirect.
REQ-019 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, EXEC, WAIT, RESP.
REQ-021 in_ready SHALL equal (state==IDLE) or (state==RESP and out_ready) and SHALL be 0 when flush is high.
REQ-022 Accept (in_valid and in_ready) SHALL capture in_multi, in_is_branch and in_rd, assert ex_en in the same cycle, and move to EXEC.
REQ-023 EXEC, single-cycle op: capture ex_result into out_data, capture ex_branch_pc, and move to RESP; accept-to-out_valid latency is 2 cycles.
REQ-024 EXEC, multi-cycle op: load the 4-bit counter with MUL_LAT-2 and move to WAIT.
REQ-025 WAIT: decrement the counter each cycle; at counter==0, capture ex_result and move to RESP; accept-to-out_valid latency is MUL_LAT+1 cycles.
REQ-026 out_valid SHALL be high exactly in RESP; out_data and out_rd SHALL hold stable until the handshake completes.
REQ-027 RESP with out_ready high: if a new accept occurs in the same cycle, move to EXEC (back-to-back, no bubble); otherwise move to IDLE.
REQ-028 RESP with out_ready low: remain in RESP.
REQ-029 redirect SHALL pulse in the out handshake cycle only when the op is a branch and out_data[0]==1; redirect_pc = captured ex_branch_pc.
REQ-030 After a taken-branch handshake, the sequencer SHALL ignore any same-cycle accept and return to IDLE.
REQ-031 flush SHALL override all other events: next state IDLE, counter cleared, no redirect, no ex_en.
REQ-032 A flush in RESP drops the pending result; out_valid falls the next cycle.

Reset
REQ-033 While rst_n is low, state SHALL be IDLE and the counter 0.
REQ-034 While rst_n is low, out_valid, redirect, ex_en and busy SHALL be 0, and out_data, out_rd and redirect_pc SHALL be 0.
REQ-035 Reset asserted mid-WAIT or mid-RESP SHALL discard the operation immediately and asynchronously.
REQ-036 After rst_n deasserts, in_ready SHALL be 1 in the first clock cycle.

Verification
REQ-037 Single-cycle ALU op, in_rd=5, ex_result=0x12345678, out_ready=1 -> out_valid at accept+2, out_data=0x12345678, out_rd=5, in_ready high the same cycle.
REQ-038 MUL_LAT=4, multi-cycle op -> ex_en at accept, out_valid at accept+5, busy high for 5 cycles.
REQ-039 Branch, ex_result=0xFFFFFFFF, ex_branch_pc=0x80000010 -> redirect=1 for one cycle with redirect_pc=0x80000010, out_rd=0, the same-cycle in_valid is not accepted.
REQ-040 out_ready held low for 3 cycles in RESP -> out_valid and out_data stable, in_ready=0, no redirect until out_ready rises.
REQ-041 flush in WAIT, and separately in RESP -> IDLE next cycle, out_valid=0, no redirect, in_ready=1 the cycle after flush drops.
REQ-042 rst_n pulsed low mid-WAIT -> all outputs 0 immediately; first instruction after release completes with the correct latency.
